// File: rtl/seg_bcd_counter_display.sv
// seg_bcd_counter_display: N-digit BCD up/down counter with a multiplexed 7-segment scan driver
module seg_bcd_counter_display #(
    parameter int DIGITS         = 2,
    parameter int TICK_DIV       = 50_000_000,
    parameter int SCAN_DIV       = 50_000,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_bcd,
    input  logic                  blank_lz,
    output logic [4*DIGITS-1:0]   cnt_bcd,
    output logic                  wrap,
    output logic [DIGITS-1:0]     cs,
    output logic [7:0]            seg
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam logic [79:0] SEG_LUT = 80'h90_80_F8_82_92_99_B0_A4_F9_C0;
    localparam logic [7:0] SEG_OFF = SEG_ACTIVE_LOW != 0 ? 8'hFF : 8'h00;
    logic [TW-1:0] tick_cnt;
    logic [SW-1:0] scan_cnt;
    logic [IW-1:0] idx;
    logic tick, c;
    logic [3:0] d, cur;
    logic [4*DIGITS-1:0] nxt, ld;
    logic [DIGITS-1:0] hz;
    logic [7:0] seg_al;
    assign tick = tick_cnt == TW'(TICK_DIV - 1);
    always_comb begin
        c = 1'b1;
        d = '0;
        nxt = cnt_bcd;
        ld = load_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            d = cnt_bcd[4*i +: 4];
            nxt[4*i +: 4] = !c ? d : up_dn ? (d == 4'd9 ? 4'd0 : d + 4'd1) : (d == 4'd0 ? 4'd9 : d - 4'd1);
            c = c & (up_dn ? d == 4'd9 : d == 4'd0);
            ld[4*i +: 4] = load_bcd[4*i +: 4] > 4'd9 ? 4'd9 : load_bcd[4*i +: 4];
        end
    end
    for (genvar g = 0; g < DIGITS; g++) begin : g_hz
        assign hz[g] = ~|cnt_bcd[4*DIGITS-1:4*g];
    end
    assign cur = cnt_bcd[{idx, 2'b00} +: 4];
    assign seg_al = (blank_lz && idx != '0 && hz[idx]) ? 8'hFF : SEG_LUT[{cur, 3'b000} +: 8];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            cnt_bcd <= '0;
            wrap <= 1'b0;
        end else if (load) begin
            tick_cnt <= '0;
            cnt_bcd <= ld;
            wrap <= 1'b0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            cnt_bcd <= tick && en ? nxt : cnt_bcd;
            wrap <= tick && en && c;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            idx <= '0;
        end else begin
            scan_cnt <= scan_cnt == SW'(SCAN_DIV - 1) ? '0 : scan_cnt + 1'b1;
            idx <= scan_cnt != SW'(SCAN_DIV - 1) ? idx : idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs <= '1;
            seg <= SEG_OFF;
        end else begin
            cs <= ~(DIGITS'(1) << idx);
            seg <= SEG_ACTIVE_LOW != 0 ? seg_al : ~seg_al;
        end
    end
endmodule
